// File: rtl/sync_fifo_prog.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_prog
//  Description : Synchronous FIFO with programmable almost-empty/almost-full
//                thresholds, a read pipeline of configurable latency with an
//                out_valid strobe, synchronous flush and sticky
//                overflow/underflow flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_prog #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 4,
    parameter int DEPTH  = 2**AWIDTH,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DWIDTH-1:0] in,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic              err_clr,
    input  logic [AWIDTH:0]   ae_thresh,
    input  logic [AWIDTH:0]   af_thresh,
    output logic [DWIDTH-1:0] out,
    output logic              out_valid,
    output logic              empty,
    output logic              almostempty,
    output logic              full,
    output logic              almostfull,
    output logic [AWIDTH:0]   num,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [AWIDTH:0] c_one   = {{AWIDTH{1'b0}}, 1'b1};
    localparam logic [AWIDTH:0] c_depth = (AWIDTH+1)'(DEPTH);

    // Storage body; deliberately not reset, reads are blocked while empty.
    logic [DWIDTH-1:0] mem [DEPTH];

    // Pointers carry one extra wrap bit; the RAM uses the low AWIDTH bits.
    logic [AWIDTH:0]   wptr_q, wptr_d;
    logic [AWIDTH:0]   rptr_q, rptr_d;
    logic [AWIDTH:0]   num_q, num_d;

    logic [DWIDTH-1:0] out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    // Read pipeline: stage 0 captures the RAM word at the pop edge, the last
    // stage feeds the output register, giving RD_LAT edges pop-to-out.
    logic [RD_LAT-1:0] pipe_valid_q, pipe_valid_d;
    logic [DWIDTH-1:0] pipe_data_q [RD_LAT];
    logic [DWIDTH-1:0] pipe_data_d [RD_LAT];

    logic              w_push_ok;
    logic              w_pop_ok;
    logic              w_wr_en;
    logic              w_rd_en;

    // Status decode from registered occupancy; thresholds act immediately.
    assign empty       = (num_q == '0);
    assign full        = (num_q == c_depth);
    assign almostempty = (num_q <= ae_thresh);
    assign almostfull  = (num_q >= af_thresh);
    assign num         = num_q;
    assign out         = out_q;
    assign out_valid   = out_valid_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

    // A full FIFO still accepts a push when a pop frees a slot in the same edge.
    assign w_pop_ok  = pop & ~empty;
    assign w_push_ok = push & (~full | w_pop_ok);
    assign w_wr_en   = w_push_ok & ~flush;
    assign w_rd_en   = w_pop_ok & ~flush;

    // Pointer and occupancy update; flush wins over push and pop.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        num_d  = num_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            num_d  = '0;
        end else begin
            if (w_wr_en) begin
                wptr_d = wptr_q + c_one;
            end
            if (w_rd_en) begin
                rptr_d = rptr_q + c_one;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   num_d = num_q + c_one;
                2'b01:   num_d = num_q - c_one;
                default: num_d = num_q;
            endcase
        end
    end

    // Sticky error flags: clear first so a same-cycle new error wins.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (push & ~w_push_ok & ~flush) begin
            overflow_d = 1'b1;
        end
        if (pop & ~w_pop_ok & ~flush) begin
            underflow_d = 1'b1;
        end
    end

    // Read pipeline shift and output register; flush cancels in-flight reads.
    always_comb begin
        pipe_valid_d    = '0;
        pipe_data_d     = pipe_data_q;
        pipe_valid_d[0] = w_rd_en;
        if (w_rd_en) begin
            pipe_data_d[0] = mem[rptr_q[AWIDTH-1:0]];
        end
        for (int k = 1; k < RD_LAT; k++) begin
            pipe_valid_d[k] = pipe_valid_q[k-1];
            pipe_data_d[k]  = pipe_data_q[k-1];
        end
        if (flush) begin
            pipe_valid_d = '0;
        end
        out_valid_d = pipe_valid_q[RD_LAT-1] & ~flush;
        out_d       = out_valid_d ? pipe_data_q[RD_LAT-1] : out_q;
    end

    // RAM write port.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem[wptr_q[AWIDTH-1:0]] <= in;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            num_q        <= '0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            pipe_valid_q <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                pipe_data_q[k] <= '0;
            end
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            num_q        <= num_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_data_q  <= pipe_data_d;
        end
    end

endmodule
`default_nettype wire
